// File: rtl/sha256_stream_core.sv
// sha256_stream_core: streaming SHA-256/SHA-224 compression engine, 1/2/4 rounds per clock,
// with the message schedule computed on the fly in a 16-word sliding window.
module sha256_stream_core #(
    parameter int MODE_224 = 0,
    parameter int UNROLL = 1
) (
    input  logic         clk_in,
    input  logic         rst_in,
    input  logic         init_in,
    input  logic [31:0]  word_in,
    input  logic         word_valid_in,
    output logic         word_ready_out,
    output logic         busy_out,
    output logic         digest_valid_out,
    output logic [255:0] digest_out,
    output logic [31:0]  block_count_out
);
    if (UNROLL != 1 && UNROLL != 2 && UNROLL != 4) begin : g_bad_unroll
        $error("UNROLL must be 1, 2 or 4");
    end

    typedef enum logic [1:0] {IDLE, ROUND, FINAL} state_t;

    localparam logic [255:0] IV = (MODE_224 != 0) ?
        256'hc1059ed8367cd5073070dd17f70e5939ffc00b316858151164f98fa7befa4fa4 :
        256'h6a09e667bb67ae853c6ef372a54ff53a510e527f9b05688c1f83d9ab5be0cd19;

    localparam logic [31:0] K [64] = '{
        32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
        32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
        32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
        32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
        32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
        32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
        32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
        32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
    };

    function automatic logic [31:0] ror(input logic [31:0] x, input int n);
        return (x >> n) | (x << (32 - n));
    endfunction

    state_t       state_q, state_d;
    logic [3:0]   wcnt_q;
    logic [5:0]   rcnt_q;
    logic [31:0]  w_q [16];
    logic [31:0]  v_q [8];
    logic [31:0]  h_q [8];
    logic [255:0] digest_q;
    logic [31:0]  bcnt_q;
    logic         dv_q;
    logic [31:0]  v_d [8];
    logic [31:0]  ext [16+UNROLL];
    logic [31:0]  t1, t2;
    logic         take, last_round;

    assign take = word_valid_in && word_ready_out;
    assign last_round = rcnt_q == 6'(64 - UNROLL);

    always_ff @(posedge clk_in) begin
        if (rst_in) state_q <= IDLE;
        else state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        if (init_in) state_d = IDLE;
        else if (state_q == IDLE && take && wcnt_q == 4'd15) state_d = ROUND;
        else if (state_q == ROUND && last_round) state_d = FINAL;
        else if (state_q == FINAL) state_d = IDLE;
    end

    always_comb begin
        word_ready_out = state_q == IDLE && !init_in;
        busy_out = state_q != IDLE;
    end

    // UNROLL chained rounds; v_d holds a..h after the last one
    always_comb begin
        for (int i = 0; i < 8; i++) v_d[i] = v_q[i];
        t1 = '0;
        t2 = '0;
        for (int j = 0; j < UNROLL; j++) begin
            t1 = v_d[7] + (ror(v_d[4], 6) ^ ror(v_d[4], 11) ^ ror(v_d[4], 25))
               + ((v_d[4] & v_d[5]) ^ (~v_d[4] & v_d[6])) + K[rcnt_q + 6'(j)] + w_q[j];
            t2 = (ror(v_d[0], 2) ^ ror(v_d[0], 13) ^ ror(v_d[0], 22))
               + ((v_d[0] & v_d[1]) ^ (v_d[0] & v_d[2]) ^ (v_d[1] & v_d[2]));
            v_d[7] = v_d[6];
            v_d[6] = v_d[5];
            v_d[5] = v_d[4];
            v_d[4] = v_d[3] + t1;
            v_d[3] = v_d[2];
            v_d[2] = v_d[1];
            v_d[1] = v_d[0];
            v_d[0] = t1 + t2;
        end
    end

    always_comb begin
        for (int i = 0; i < 16; i++) ext[i] = w_q[i];
        for (int j = 0; j < UNROLL; j++)
            ext[16+j] = (ror(ext[14+j], 17) ^ ror(ext[14+j], 19) ^ (ext[14+j] >> 10)) + ext[9+j]
                      + (ror(ext[1+j], 7) ^ ror(ext[1+j], 18) ^ (ext[1+j] >> 3)) + ext[j];
    end

    always_ff @(posedge clk_in) begin
        if (rst_in || init_in) begin
            wcnt_q <= '0;
            rcnt_q <= '0;
            bcnt_q <= '0;
            dv_q <= 1'b0;
            for (int i = 0; i < 8; i++) h_q[i] <= IV[255 - 32*i -: 32];
            if (rst_in) digest_q <= '0;
        end else begin
            dv_q <= state_q == FINAL;
            if (take) begin
                for (int i = 0; i < 15; i++) w_q[i] <= w_q[i+1];
                w_q[15] <= word_in;
                wcnt_q <= wcnt_q + 4'd1;
                if (wcnt_q == 4'd15) begin
                    for (int i = 0; i < 8; i++) v_q[i] <= h_q[i];
                    rcnt_q <= '0;
                end
            end
            if (state_q == ROUND) begin
                for (int i = 0; i < 8; i++) v_q[i] <= v_d[i];
                for (int i = 0; i < 16; i++) w_q[i] <= ext[i+UNROLL];
                rcnt_q <= rcnt_q + 6'(UNROLL);
            end
            if (state_q == FINAL) begin
                for (int i = 0; i < 8; i++) begin
                    h_q[i] <= h_q[i] + v_q[i];
                    digest_q[255 - 32*i -: 32] <= (MODE_224 != 0 && i == 7) ? 32'h0 : h_q[i] + v_q[i];
                end
                bcnt_q <= bcnt_q + 32'd1;
            end
        end
    end

    assign digest_valid_out = dv_q;
    assign digest_out = digest_q;
    assign block_count_out = bcnt_q;
endmodule

// File: tb/tb_sha256_stream_core.sv
// tb_sha256_stream_core: directed-vector bench over four core configurations
// (U1/SHA-256, U2/SHA-256, U4/SHA-256, U1/SHA-224), each with its own stream.
module tb_sha256_stream_core;
    typedef logic [31:0] blk_t [16];

    localparam logic [255:0] D_ABC   = 256'hba7816bf8f01cfea414140de5dae2223b00361a396177a9cb410ff61f20015ad;
    localparam logic [255:0] D_TWO   = 256'h248d6a61d20638b8e5c026930c3e6039a33ce45964ff2167f6ecedd419db06c1;
    localparam logic [255:0] D_EMPTY = 256'he3b0c44298fc1c149afbf4c8996fb92427ae41e4649b934ca495991b7852b855;
    localparam logic [223:0] D_224   = 224'h23097d223405d8228642a477bda255b32aadbce4bda0b3f7e36c9da7;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic init_v [4] = '{default: 1'b0};
    logic valid_v [4] = '{default: 1'b0};
    logic [31:0] word_v [4] = '{default: 32'h0};
    logic rdy [4], busy [4], dv [4];
    logic [255:0] dig [4];
    logic [31:0] bcnt [4];
    int xfer [4] = '{default: 0};
    int checks = 0;
    int errors = 0;
    blk_t abc, empty, two_a, two_b;

    always #5 clk = ~clk;

    always @(posedge clk)
        for (int k = 0; k < 4; k++)
            if (valid_v[k] && rdy[k]) xfer[k] <= xfer[k] + 1;

    sha256_stream_core #(.MODE_224(0), .UNROLL(1)) u_u1 (
        .clk_in(clk), .rst_in(rst), .init_in(init_v[0]), .word_in(word_v[0]), .word_valid_in(valid_v[0]),
        .word_ready_out(rdy[0]), .busy_out(busy[0]), .digest_valid_out(dv[0]), .digest_out(dig[0]),
        .block_count_out(bcnt[0]));
    sha256_stream_core #(.MODE_224(0), .UNROLL(2)) u_u2 (
        .clk_in(clk), .rst_in(rst), .init_in(init_v[1]), .word_in(word_v[1]), .word_valid_in(valid_v[1]),
        .word_ready_out(rdy[1]), .busy_out(busy[1]), .digest_valid_out(dv[1]), .digest_out(dig[1]),
        .block_count_out(bcnt[1]));
    sha256_stream_core #(.MODE_224(0), .UNROLL(4)) u_u4 (
        .clk_in(clk), .rst_in(rst), .init_in(init_v[2]), .word_in(word_v[2]), .word_valid_in(valid_v[2]),
        .word_ready_out(rdy[2]), .busy_out(busy[2]), .digest_valid_out(dv[2]), .digest_out(dig[2]),
        .block_count_out(bcnt[2]));
    sha256_stream_core #(.MODE_224(1), .UNROLL(1)) u_224 (
        .clk_in(clk), .rst_in(rst), .init_in(init_v[3]), .word_in(word_v[3]), .word_valid_in(valid_v[3]),
        .word_ready_out(rdy[3]), .busy_out(busy[3]), .digest_valid_out(dv[3]), .digest_out(dig[3]),
        .block_count_out(bcnt[3]));

    task automatic send_word(input int k, input logic [31:0] w);
        int n = 0;
        word_v[k] = w;
        valid_v[k] = 1'b1;
        while (!rdy[k] && n < 500) begin
            @(negedge clk);
            n++;
        end
        if (n >= 500) begin
            checks++;
            errors++;
            $display("FAIL send_word_timeout dut%0d: ready never rose within %0d cycles", k, n);
        end
        @(posedge clk);
        #1;
        valid_v[k] = 1'b0;
    endtask

    task automatic send_block(input int k, input blk_t b, input int maxgap);
        for (int i = 0; i < 16; i++) begin
            if (maxgap > 0) repeat ($urandom_range(0, maxgap)) begin
                @(posedge clk);
                #1;
            end
            send_word(k, b[i]);
        end
    endtask

    task automatic wait_digest(input int k, output int lat);
        lat = 0;
        do begin
            @(posedge clk);
            #1;
            lat++;
        end while (!dv[k] && lat < 300);
        if (!dv[k]) begin
            checks++;
            errors++;
            $display("FAIL digest_timeout dut%0d: no digest_valid_out within %0d edges", k, lat);
        end
    endtask

    task automatic do_init(input int k);
        init_v[k] = 1'b1;
        #1;
        checks++;
        if (rdy[k] !== 1'b0) begin
            errors++;
            $display("FAIL init_blocks_ready dut%0d: got %b expected 0", k, rdy[k]);
        end
        @(posedge clk);
        #1;
        init_v[k] = 1'b0;
    endtask

    task automatic test_reset();
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        for (int k = 0; k < 4; k++) begin
            checks += 5;
            if (dig[k] !== '0) begin errors++; $display("FAIL reset_digest dut%0d: got %h expected 0", k, dig[k]); end
            if (bcnt[k] !== 32'd0) begin errors++; $display("FAIL reset_bcnt dut%0d: got %0d expected 0", k, bcnt[k]); end
            if (dv[k] !== 1'b0) begin errors++; $display("FAIL reset_dv dut%0d: got %b expected 0", k, dv[k]); end
            if (busy[k] !== 1'b0) begin errors++; $display("FAIL reset_busy dut%0d: got %b expected 0", k, busy[k]); end
            if (rdy[k] !== 1'b1) begin errors++; $display("FAIL reset_ready dut%0d: got %b expected 1", k, rdy[k]); end
        end
    endtask

    task automatic test_sha256_abc();
        int lat;
        send_block(0, abc, 0);
        checks += 2;
        if (busy[0] !== 1'b1) begin errors++; $display("FAIL abc_busy: got %b expected 1", busy[0]); end
        if (rdy[0] !== 1'b0) begin errors++; $display("FAIL abc_ready_in_round: got %b expected 0", rdy[0]); end
        wait_digest(0, lat);
        checks += 4;
        if (lat != 65) begin errors++; $display("FAIL abc_latency: got %0d expected 65", lat); end
        if (dig[0] !== D_ABC) begin errors++; $display("FAIL abc_digest: got %h expected %h", dig[0], D_ABC); end
        if (bcnt[0] !== 32'd1) begin errors++; $display("FAIL abc_bcnt: got %0d expected 1", bcnt[0]); end
        if (rdy[0] !== 1'b1) begin errors++; $display("FAIL abc_ready_with_dv: got %b expected 1", rdy[0]); end
        @(posedge clk);
        #1;
        checks++;
        if (dv[0] !== 1'b0) begin errors++; $display("FAIL abc_dv_pulse: got %b expected 0", dv[0]); end
    endtask

    task automatic test_two_block(input int k, input int exp_lat);
        int lat;
        do_init(k);
        send_block(k, two_a, 0);
        wait_digest(k, lat);
        checks++;
        if (lat != exp_lat) begin errors++; $display("FAIL two_latency1 dut%0d: got %0d expected %0d", k, lat, exp_lat); end
        send_block(k, two_b, 1);
        wait_digest(k, lat);
        checks += 3;
        if (lat != exp_lat) begin errors++; $display("FAIL two_latency2 dut%0d: got %0d expected %0d", k, lat, exp_lat); end
        if (dig[k] !== D_TWO) begin errors++; $display("FAIL two_digest dut%0d: got %h expected %h", k, dig[k], D_TWO); end
        if (bcnt[k] !== 32'd2) begin errors++; $display("FAIL two_bcnt dut%0d: got %0d expected 2", k, bcnt[k]); end
    endtask

    task automatic test_sha224();
        int lat;
        send_block(3, abc, 0);
        wait_digest(3, lat);
        checks += 3;
        if (lat != 65) begin errors++; $display("FAIL sha224_latency: got %0d expected 65", lat); end
        if (dig[3][255:32] !== D_224) begin errors++; $display("FAIL sha224_digest: got %h expected %h", dig[3][255:32], D_224); end
        if (dig[3][31:0] !== 32'h0) begin errors++; $display("FAIL sha224_low_word: got %h expected 0", dig[3][31:0]); end
    endtask

    task automatic test_backpressure();
        int lat;
        int x0;
        do_init(0);
        x0 = xfer[0];
        send_block(0, empty, 3);
        word_v[0] = 32'hdeadbeef;
        valid_v[0] = 1'b1;
        wait_digest(0, lat);
        valid_v[0] = 1'b0;
        checks += 3;
        if (xfer[0] - x0 != 16) begin errors++; $display("FAIL bp_words_taken: got %0d expected 16", xfer[0] - x0); end
        if (dig[0] !== D_EMPTY) begin errors++; $display("FAIL bp_digest: got %h expected %h", dig[0], D_EMPTY); end
        if (bcnt[0] !== 32'd1) begin errors++; $display("FAIL bp_bcnt: got %0d expected 1", bcnt[0]); end
    endtask

    task automatic test_abort();
        int lat;
        int x0;
        int seen = 0;
        for (int i = 0; i < 7; i++) send_word(0, abc[i]);
        do_init(0);
        checks++;
        if (bcnt[0] !== 32'd0) begin errors++; $display("FAIL abort_partial_bcnt: got %0d expected 0", bcnt[0]); end
        send_block(0, abc, 0);
        repeat (30) @(posedge clk);
        #1;
        do_init(0);
        repeat (80) begin
            @(posedge clk);
            #1;
            if (dv[0]) seen++;
        end
        checks += 2;
        if (seen != 0) begin errors++; $display("FAIL abort_round_dv: got %0d pulses expected 0", seen); end
        if (bcnt[0] !== 32'd0) begin errors++; $display("FAIL abort_round_bcnt: got %0d expected 0", bcnt[0]); end
        x0 = xfer[0];
        init_v[0] = 1'b1;
        valid_v[0] = 1'b1;
        word_v[0] = 32'h12345678;
        @(posedge clk);
        #1;
        init_v[0] = 1'b0;
        valid_v[0] = 1'b0;
        checks++;
        if (xfer[0] != x0) begin errors++; $display("FAIL init_wins: got %0d words taken expected 0", xfer[0] - x0); end
        send_block(0, abc, 2);
        wait_digest(0, lat);
        checks += 2;
        if (dig[0] !== D_ABC) begin errors++; $display("FAIL abort_then_abc: got %h expected %h", dig[0], D_ABC); end
        if (bcnt[0] !== 32'd1) begin errors++; $display("FAIL abort_then_bcnt: got %0d expected 1", bcnt[0]); end
    endtask

    task automatic test_reset_mid();
        int lat;
        send_block(0, abc, 0);
        repeat (20) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        checks += 5;
        if (busy[0] !== 1'b0) begin errors++; $display("FAIL rstmid_busy: got %b expected 0", busy[0]); end
        if (dig[0] !== '0) begin errors++; $display("FAIL rstmid_digest: got %h expected 0", dig[0]); end
        if (rdy[0] !== 1'b1) begin errors++; $display("FAIL rstmid_ready: got %b expected 1", rdy[0]); end
        if (bcnt[0] !== 32'd0) begin errors++; $display("FAIL rstmid_bcnt: got %0d expected 0", bcnt[0]); end
        if (dv[0] !== 1'b0) begin errors++; $display("FAIL rstmid_dv: got %b expected 0", dv[0]); end
        rst = 1'b0;
        send_block(0, abc, 0);
        wait_digest(0, lat);
        checks += 2;
        if (dig[0] !== D_ABC) begin errors++; $display("FAIL rstmid_abc: got %h expected %h", dig[0], D_ABC); end
        if (bcnt[0] !== 32'd1) begin errors++; $display("FAIL rstmid_bcnt_after: got %0d expected 1", bcnt[0]); end
    endtask

    initial begin
        abc = '{default: 32'h0};
        abc[0] = 32'h61626380;
        abc[15] = 32'h00000018;
        empty = '{default: 32'h0};
        empty[0] = 32'h80000000;
        two_a = '{32'h61626364, 32'h62636465, 32'h63646566, 32'h64656667, 32'h65666768, 32'h66676869,
                  32'h6768696a, 32'h68696a6b, 32'h696a6b6c, 32'h6a6b6c6d, 32'h6b6c6d6e, 32'h6c6d6e6f,
                  32'h6d6e6f70, 32'h6e6f7071, 32'h80000000, 32'h00000000};
        two_b = '{default: 32'h0};
        two_b[15] = 32'h000001c0;
        test_reset();
        test_sha256_abc();
        test_two_block(1, 33);
        test_two_block(2, 17);
        test_sha224();
        test_backpressure();
        test_abort();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete, %0d errors so far", errors);
        $fatal(1);
    end
endmodule
